// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: the tracked-entry record, the
// default register address width and the freeze/flush control encoding.
package hazard_pkg;

  localparam int REG_AW   = 4;
  localparam int NUM_REGS = 1 << REG_AW;

  // One in-flight register-writing instruction
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              is_load;
  } sb_entry_t;

  // Per-cycle entry control; flush outranks freeze, freeze outranks shift
  typedef enum logic [1:0] {
    SB_SHIFT = 2'd0,
    SB_HOLD  = 2'd1,
    SB_CLEAR = 2'd2
  } sb_ctl_e;

  function automatic sb_ctl_e sb_ctl(input logic freeze, input logic flush);
    if (flush)       return SB_CLEAR;
    else if (freeze) return SB_HOLD;
    else             return SB_SHIFT;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One tracked pipeline stage of the hazard scoreboard. Holds, clears or
// loads its entry and compares its destination against every ID source.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  sb_ctl_e                   ctl_i,
  input  sb_entry_t                 load_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_i,
  input  logic [NUM_SRC-1:0]        src_used_i,
  output sb_entry_t                 entry_o,
  output logic [NUM_SRC-1:0]        match_o
);

  sb_entry_t entry_q;
  sb_entry_t entry_d;

  // Select next entry contents from the shared stage control
  always_comb begin
    entry_d = entry_q;
    case (ctl_i)
      SB_SHIFT: entry_d = load_i;
      SB_CLEAR: entry_d = '0;
      default:  entry_d = entry_q;
    endcase
  end

  // Entry register, invalid out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  // Per-operand destination/source comparator, gated by use mask and validity
  always_comb begin
    match_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      match_o[i] = id_valid_i & src_used_i[i] & entry_q.valid &
                   (entry_q.dest == src_i[i*REG_AW +: REG_AW]);
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised RAW hazard scoreboard for the in-order pipeline. Tracks DEPTH
// in-flight destinations after ID and stalls IF/ID on unresolved sources.
// Build option: define HAZARD_FWD_EN when the forwarding unit is present;
// then only a load in EXE (load-use) stalls. Undefined: any match stalls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = hazard_pkg::REG_AW,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_wb_en,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic                      id_is_load,
  input  logic                      freeze,
  input  logic                      flush,
  input  logic                      stat_clr,
  output logic                      hazard,
  output logic [NUM_SRC-1:0]        hazard_src,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  sb_ctl_e            ctl;
  sb_entry_t          issue;
  sb_entry_t          ent_in [DEPTH];
  sb_entry_t          ent_q  [DEPTH];
  logic [NUM_SRC-1:0] match  [DEPTH];
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;

  assign ctl = sb_ctl(freeze, flush);

  // A stalled ID issues a bubble, so its destination is never recorded twice
  assign issue = '{valid: id_valid & id_wb_en & ~hazard, dest: id_dest, is_load: id_is_load};

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    if (k == 0) begin : g_head
      assign ent_in[k] = issue;
    end else begin : g_tail
      assign ent_in[k] = ent_q[k-1];
    end

    hazard_sb_entry #(
      .NUM_SRC (NUM_SRC)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .ctl_i      (ctl),
      .load_i     (ent_in[k]),
      .id_valid_i (id_valid),
      .src_i      (id_src),
      .src_used_i (id_src_used),
      .entry_o    (ent_q[k]),
      .match_o    (match[k])
    );
  end

  // Qualify matches into per-operand stall flags
  always_comb begin
    hazard_src = '0;
`ifdef HAZARD_FWD_EN
    if (ent_q[0].is_load) hazard_src = match[0];
`else
    for (int k = 0; k < DEPTH; k++) begin
      hazard_src = hazard_src | match[k];
    end
`endif
  end

  assign hazard = |hazard_src;

  // Saturating stall counter next state; clear beats increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)
      stall_cnt_d = '0;
    else if (hazard && !freeze && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH=2, CNT_W=4 so the
// saturation boundary is reachable quickly). Expected values follow the
// HAZARD_FWD_EN build option.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid;
  logic [7:0]          id_src;
  logic [1:0]          id_src_used;
  logic                id_wb_en;
  logic [3:0]          id_dest;
  logic                id_is_load;
  logic                freeze;
  logic                flush;
  logic                stat_clr;
  logic                hazard;
  logic [1:0]          hazard_src;
  logic [TB_CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_scoreboard #(
    .REG_AW  (4),
    .NUM_SRC (2),
    .DEPTH   (2),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_wb_en    (id_wb_en),
    .id_dest     (id_dest),
    .id_is_load  (id_is_load),
    .freeze      (freeze),
    .flush       (flush),
    .stat_clr    (stat_clr),
    .hazard      (hazard),
    .hazard_src  (hazard_src),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [1:0] used, input logic wb, input logic [3:0] dest,
                        input logic ld);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_wb_en    = wb;
    id_dest     = dest;
    id_is_load  = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    freeze   = 1'b0;
    flush    = 1'b0;
    stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int  c;
  bit  timeout;

  initial begin
    // ---- reset state ----
    do_reset();
    set_id(1'b1, 4'd1, 4'd2, 2'b11, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk("rst_hazard", hazard, 0);
    chk("rst_hsrc", hazard_src, 0);
    chk("rst_cnt", stall_cnt, 0);

    // ---- ALU producer R3, consumer src0=R3 ----
    do_reset();
    set_id(1'b1, 4'd1, 4'd2, 2'b11, 1'b1, 4'd3, 1'b0);
    @(negedge clk);
    chk("alu_prod_hz", hazard, 0);
    next();
    set_id(1'b1, 4'd3, 4'd1, 2'b11, 1'b1, 4'd6, 1'b0);
    @(negedge clk);
    chk("alu_c1_hz", hazard, FWD ? 0 : 1);
    chk("alu_c1_hsrc", hazard_src, FWD ? 2'b00 : 2'b01);
    next();
    @(negedge clk);
    chk("alu_c2_hz", hazard, FWD ? 0 : 1);
    next();
    @(negedge clk);
    chk("alu_c3_hz", hazard, 0);
    chk("alu_cnt", stall_cnt, FWD ? 0 : 2);

    // ---- load-use: LDR R5, consumer src1=R5 ----
    do_reset();
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 4'd5, 1'b1);
    next();
    set_id(1'b1, 4'd7, 4'd5, 2'b11, 1'b1, 4'd8, 1'b0);
    @(negedge clk);
    chk("ld_c1_hz", hazard, 1);
    chk("ld_c1_hsrc", hazard_src, 2'b10);
    next();
    @(negedge clk);
    chk("ld_c2_hz", hazard, FWD ? 0 : 1);
    next();
    @(negedge clk);
    chk("ld_c3_hz", hazard, 0);
    chk("ld_cnt", stall_cnt, FWD ? 1 : 2);

    // ---- use mask: src0 matches but only src1 used ----
    do_reset();
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 4'd3, 1'b0);
    next();
    set_id(1'b1, 4'd3, 4'd9, 2'b10, 1'b1, 4'd4, 1'b0);
    @(negedge clk);
    chk("mask_hz", hazard, 0);
    chk("mask_hsrc", hazard_src, 2'b00);

    // ---- freeze holds entries and counter, flush beats freeze ----
    do_reset();
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 4'd4, 1'b1);
    next();
    set_id(1'b1, 4'd4, 4'd0, 2'b01, 1'b0, 4'd0, 1'b0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("frz%0d_hz", i), hazard, 1);
      next();
    end
    @(negedge clk);
    chk("frz_cnt", stall_cnt, 0);
    flush = 1'b1;
    chk("fl_same_cycle_hz", hazard, 1);
    next();
    flush  = 1'b0;
    freeze = 1'b0;
    @(negedge clk);
    chk("fl_after_hz", hazard, 0);
    chk("fl_after_hsrc", hazard_src, 2'b00);
    chk("fl_after_cnt", stall_cnt, 0);

    // ---- reset asserted mid-stall ----
    do_reset();
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 4'd4, 1'b1);
    next();
    set_id(1'b1, 4'd4, 4'd0, 2'b01, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk("mid_pre_hz", hazard, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_hz", hazard, 0);
    next();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_hz", hazard, 0);
    chk("mid_post_cnt", stall_cnt, 0);

    // ---- counter saturation and clear priority ----
    do_reset();
    timeout = 1'b0;
    for (int it = 0; it < 20; it++) begin
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 4'd5, 1'b1);
      next();
      set_id(1'b1, 4'd5, 4'd0, 2'b01, 1'b0, 4'd0, 1'b0);
      c = 0;
      @(negedge clk);
      while (hazard && c < 6) begin
        next();
        @(negedge clk);
        c++;
      end
      if (c >= 6) timeout = 1'b1;
      next();
    end
    chk("sat_release_bound", timeout, 0);
    chk("sat_cnt", stall_cnt, 15);
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 4'd5, 1'b1);
    next();
    set_id(1'b1, 4'd5, 4'd0, 2'b01, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk("sat_hold_hz", hazard, 1);
    next();
    idle();
    @(negedge clk);
    chk("sat_hold_cnt", stall_cnt, 15);
    repeat (3) next();
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 1'b1, 4'd5, 1'b1);
    next();
    set_id(1'b1, 4'd5, 4'd0, 2'b01, 1'b0, 4'd0, 1'b0);
    stat_clr = 1'b1;
    @(negedge clk);
    chk("clr_hz", hazard, 1);
    next();
    stat_clr = 1'b0;
    idle();
    @(negedge clk);
    chk("clr_cnt", stall_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
